// File: rtl/alu_exec_ctrl.sv
// Multi-cycle execute sequencer in front of a combinational 8-bit ALU: registered operands,
// result capture and register-file write-back. Define ALU_CARRY_INT_EN to derive carry internally.
module alu_exec_ctrl #(
  parameter int unsigned NREGS   = 4,
  parameter logic [7:0]  RST_VAL = 8'h00
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     instr_valid,
  output logic                     instr_ready,
  input  logic [3:0]               instr_op,
  input  logic [$clog2(NREGS)-1:0] instr_rd,
  input  logic [$clog2(NREGS)-1:0] instr_rs,
  input  logic                     instr_use_imm,
  input  logic [7:0]               instr_imm,
  output logic [7:0]               alu_a,
  output logic [7:0]               alu_b,
  output logic                     alu_cin,
  output logic [3:0]               alu_op,
  input  logic [7:0]               alu_sum,
  input  logic                     alu_cout,
  output logic                     wb_valid,
  output logic [$clog2(NREGS)-1:0] wb_rd,
  output logic [7:0]               wb_data,
  output logic                     flag_z,
  output logic                     flag_c,
  output logic                     busy,
  input  logic [$clog2(NREGS)-1:0] dbg_addr,
  output logic [7:0]               dbg_data
);

  localparam int unsigned AW = $clog2(NREGS);

  localparam logic [3:0] OpNop  = 4'b0000;
  localparam logic [3:0] OpSub  = 4'b0001;
  localparam logic [3:0] OpAdd  = 4'b0010;
  localparam logic [3:0] OpAnd  = 4'b0100;
  localparam logic [3:0] OpXor  = 4'b0101;
  localparam logic [3:0] OpMovi = 4'b1111;

  typedef enum logic [1:0] {StIdle, StOper, StExec, StWb} state_e;

  state_e          state_q, state_d;
  logic [3:0]      op_q, op_d;
  logic [AW-1:0]   rd_q, rd_d, rs_q, rs_d;
  logic            use_imm_q, use_imm_d;
  logic [7:0]      imm_q, imm_d;
  logic [7:0]      alu_a_q, alu_a_d, alu_b_q, alu_b_d;
  logic [3:0]      alu_op_q, alu_op_d;
  logic            wb_valid_q, wb_valid_d;
  logic [AW-1:0]   wb_rd_q, wb_rd_d;
  logic [7:0]      wb_data_q, wb_data_d;
  logic            carry_q, carry_d;
  logic            flag_z_q, flag_z_d, flag_c_q, flag_c_d;
  logic [7:0]      rf_q [NREGS];
  logic [7:0]      rf_d [NREGS];
  logic [7:0]      result;
  logic            carry;

  assign result = (op_q == OpMovi) ? alu_b_q : alu_sum;

`ifdef ALU_CARRY_INT_EN
  logic [8:0] add9, sub9;
  logic       unused_cout;
  assign unused_cout = alu_cout;
  assign add9 = {1'b0, alu_a_q} + {1'b0, alu_b_q};
  // Bit 8 of the 9-bit difference is the unsigned borrow.
  assign sub9 = {1'b0, alu_a_q} - {1'b0, alu_b_q};
  assign carry = (op_q == OpAdd) ? add9[8] :
                 (op_q == OpSub) ? sub9[8] : 1'b0;
`else
  assign carry = ((op_q == OpAdd) || (op_q == OpSub)) ? alu_cout : 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    rd_d       = rd_q;
    rs_d       = rs_q;
    use_imm_d  = use_imm_q;
    imm_d      = imm_q;
    alu_a_d    = alu_a_q;
    alu_b_d    = alu_b_q;
    alu_op_d   = alu_op_q;
    wb_valid_d = 1'b0;
    wb_rd_d    = wb_rd_q;
    wb_data_d  = wb_data_q;
    carry_d    = carry_q;
    flag_z_d   = flag_z_q;
    flag_c_d   = flag_c_q;
    rf_d       = rf_q;
    unique case (state_q)
      StIdle: begin
        if (instr_valid) begin
          op_d      = instr_op;
          rd_d      = instr_rd;
          rs_d      = instr_rs;
          use_imm_d = instr_use_imm;
          imm_d     = instr_imm;
          state_d   = StOper;
        end
      end
      StOper: begin
        alu_a_d = rf_q[rd_q];
        alu_b_d = use_imm_q ? imm_q : rf_q[rs_q];
        case (op_q)
          OpNop:                        alu_op_d = alu_op_q;
          OpAdd, OpSub, OpXor, OpMovi:  alu_op_d = op_q;
          default:                      alu_op_d = OpAnd;
        endcase
        state_d = (op_q == OpNop) ? StIdle : StExec;
      end
      StExec: begin
        wb_valid_d = 1'b1;
        wb_rd_d    = rd_q;
        wb_data_d  = result;
        carry_d    = carry;
        state_d    = StWb;
      end
      StWb: begin
        rf_d[rd_q] = wb_data_q;
        flag_z_d   = (wb_data_q == 8'h00);
        flag_c_d   = carry_q;
        state_d    = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      op_q       <= '0;
      rd_q       <= '0;
      rs_q       <= '0;
      use_imm_q  <= 1'b0;
      imm_q      <= '0;
      alu_a_q    <= '0;
      alu_b_q    <= '0;
      alu_op_q   <= '0;
      wb_valid_q <= 1'b0;
      wb_rd_q    <= '0;
      wb_data_q  <= '0;
      carry_q    <= 1'b0;
      flag_z_q   <= 1'b0;
      flag_c_q   <= 1'b0;
      for (int i = 0; i < NREGS; i++) rf_q[i] <= RST_VAL;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      rd_q       <= rd_d;
      rs_q       <= rs_d;
      use_imm_q  <= use_imm_d;
      imm_q      <= imm_d;
      alu_a_q    <= alu_a_d;
      alu_b_q    <= alu_b_d;
      alu_op_q   <= alu_op_d;
      wb_valid_q <= wb_valid_d;
      wb_rd_q    <= wb_rd_d;
      wb_data_q  <= wb_data_d;
      carry_q    <= carry_d;
      flag_z_q   <= flag_z_d;
      flag_c_q   <= flag_c_d;
      rf_q       <= rf_d;
    end
  end

  assign instr_ready = (state_q == StIdle);
  assign busy        = (state_q != StIdle);
  assign alu_a       = alu_a_q;
  assign alu_b       = alu_b_q;
  assign alu_cin     = 1'b0;
  assign alu_op      = alu_op_q;
  assign wb_valid    = wb_valid_q;
  assign wb_rd       = wb_rd_q;
  assign wb_data     = wb_data_q;
  assign flag_z      = flag_z_q;
  assign flag_c      = flag_c_q;
  assign dbg_data    = rf_q[dbg_addr];

endmodule

// File: tb/tb_alu_exec_ctrl.sv
// Directed bench for alu_exec_ctrl with a behavioural 8-bit ALU closing the loop.
module tb_alu_exec_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       instr_valid, instr_ready, instr_use_imm;
  logic [3:0] instr_op;
  logic [1:0] instr_rd, instr_rs;
  logic [7:0] instr_imm;
  logic [7:0] alu_a, alu_b, alu_sum;
  logic       alu_cin, alu_cout;
  logic [3:0] alu_op;
  logic       wb_valid;
  logic [1:0] wb_rd;
  logic [7:0] wb_data;
  logic       flag_z, flag_c, busy;
  logic [1:0] dbg_addr;
  logic [7:0] dbg_data;

  int total = 0;
  int bad   = 0;

  alu_exec_ctrl dut (
    .clk           (clk),
    .rst           (rst),
    .instr_valid   (instr_valid),
    .instr_ready   (instr_ready),
    .instr_op      (instr_op),
    .instr_rd      (instr_rd),
    .instr_rs      (instr_rs),
    .instr_use_imm (instr_use_imm),
    .instr_imm     (instr_imm),
    .alu_a         (alu_a),
    .alu_b         (alu_b),
    .alu_cin       (alu_cin),
    .alu_op        (alu_op),
    .alu_sum       (alu_sum),
    .alu_cout      (alu_cout),
    .wb_valid      (wb_valid),
    .wb_rd         (wb_rd),
    .wb_data       (wb_data),
    .flag_z        (flag_z),
    .flag_c        (flag_c),
    .busy          (busy),
    .dbg_addr      (dbg_addr),
    .dbg_data      (dbg_data)
  );

  always #5 clk = ~clk;

  // External ALU: SUB reports borrow on cout; unknown codes (incl. MOVI) give 0.
  always_comb begin
    alu_sum  = 8'h00;
    alu_cout = 1'b0;
    case (alu_op)
      4'b0010: {alu_cout, alu_sum} = {1'b0, alu_a} + {1'b0, alu_b};
      4'b0001: begin alu_sum = alu_a - alu_b; alu_cout = (alu_a < alu_b); end
      4'b0101: alu_sum = alu_a ^ alu_b;
      4'b0100: alu_sum = alu_a & alu_b;
      default: alu_sum = 8'h00;
    endcase
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic dbg(input string tag, input logic [1:0] a, input logic [7:0] e);
    dbg_addr = a;
    #1;
    chk(tag, {24'h0, dbg_data}, {24'h0, e});
  endtask

  task automatic flags(input string tag, input logic z, input logic c);
    chk({tag, ".z"}, {31'h0, flag_z}, {31'h0, z});
    chk({tag, ".c"}, {31'h0, flag_c}, {31'h0, c});
  endtask

  // Issues one instruction from IDLE and follows it until ready returns (bounded).
  // With hold set, valid stays high and imm is scrambled while busy.
  task automatic exec(input logic [3:0] op, input logic [1:0] rd, input logic [1:0] rs,
                      input logic ui, input logic [7:0] imm, input bit hold,
                      output int wbn, output int wbat, output int rdyat,
                      output logic [7:0] wbd, output logic [1:0] wbr, output logic [3:0] aop,
                      output logic b1);
    instr_valid = 1'b1; instr_op = op; instr_rd = rd; instr_rs = rs;
    instr_use_imm = ui; instr_imm = imm;
    tick();
    if (hold) instr_imm = ~imm;
    else instr_valid = 1'b0;
    wbn = 0; wbat = 0; rdyat = 0; wbd = 'x; wbr = 'x; aop = 'x; b1 = busy;
    for (int i = 1; i <= 8; i++) begin
      if (wb_valid === 1'b1) begin
        wbn++; wbat = i; wbd = wb_data; wbr = wb_rd; aop = alu_op;
      end
      if (instr_ready === 1'b1) begin
        rdyat = i;
        instr_valid = 1'b0;
        break;
      end
      tick();
    end
  endtask

  task automatic op_chk(input string tag, input logic [3:0] op, input logic [1:0] rd,
                        input logic [1:0] rs, input logic ui, input logic [7:0] imm,
                        input logic [7:0] expd);
    int wbn, wbat, rdyat;
    logic [7:0] wbd;
    logic [1:0] wbr;
    logic [3:0] aop;
    logic b1;
    exec(op, rd, rs, ui, imm, 1'b0, wbn, wbat, rdyat, wbd, wbr, aop, b1);
    chk({tag, ".wbn"}, wbn, 1);
    chk({tag, ".wbd"}, {24'h0, wbd}, {24'h0, expd});
    chk({tag, ".wbr"}, {30'h0, wbr}, {30'h0, rd});
  endtask

  int wbn, wbat, rdyat;
  logic [7:0] wbd;
  logic [1:0] wbr;
  logic [3:0] aop;
  logic b1;

  initial begin
    rst = 1'b1; instr_valid = 1'b0; instr_op = '0; instr_rd = '0; instr_rs = '0;
    instr_use_imm = 1'b0; instr_imm = '0; dbg_addr = '0;
    tick(); tick();
    rst = 1'b0;

    chk("rst.ready", {31'h0, instr_ready}, 32'd1);
    chk("rst.busy", {31'h0, busy}, 32'd0);
    chk("rst.alu_a", {24'h0, alu_a}, 32'h0);
    chk("rst.alu_b", {24'h0, alu_b}, 32'h0);
    chk("rst.alu_op", {28'h0, alu_op}, 32'h0);
    chk("rst.cin", {31'h0, alu_cin}, 32'h0);
    chk("rst.wbv", {31'h0, wb_valid}, 32'h0);
    chk("rst.wbd", {24'h0, wb_data}, 32'h0);
    chk("rst.wbr", {30'h0, wb_rd}, 32'h0);
    flags("rst", 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) dbg("rst.rf", i[1:0], 8'h00);

    op_chk("movi0", 4'b1111, 2'd0, 2'd0, 1'b1, 8'hF0, 8'hF0);
    op_chk("movi1", 4'b1111, 2'd1, 2'd0, 1'b1, 8'h20, 8'h20);
    dbg("movi.r0", 2'd0, 8'hF0);
    dbg("movi.r1", 2'd1, 8'h20);
    flags("movi", 1'b0, 1'b0);

    exec(4'b0010, 2'd0, 2'd1, 1'b0, 8'h00, 1'b0, wbn, wbat, rdyat, wbd, wbr, aop, b1);
    chk("add.wbn", wbn, 1);
    chk("add.wbd", {24'h0, wbd}, 32'h10);
    chk("add.lat", wbat, 3);
    chk("add.rdy", rdyat, 4);
    chk("add.aop", {28'h0, aop}, 32'h2);
    chk("add.busy", {31'h0, b1}, 32'd1);
    flags("add", 1'b0, 1'b1);

    op_chk("sub20", 4'b0001, 2'd1, 2'd0, 1'b1, 8'h20, 8'h00);
    flags("sub20", 1'b1, 1'b0);
    op_chk("sub01", 4'b0001, 2'd1, 2'd0, 1'b1, 8'h01, 8'hFF);
    flags("sub01", 1'b0, 1'b1);

    op_chk("xor", 4'b0101, 2'd0, 2'd0, 1'b0, 8'h00, 8'h00);
    flags("xor", 1'b1, 1'b0);

    op_chk("moviAA", 4'b1111, 2'd0, 2'd0, 1'b1, 8'hAA, 8'hAA);
    op_chk("movi0F", 4'b1111, 2'd1, 2'd0, 1'b1, 8'h0F, 8'h0F);
    exec(4'b1010, 2'd0, 2'd1, 1'b0, 8'h00, 1'b0, wbn, wbat, rdyat, wbd, wbr, aop, b1);
    chk("and.aop", {28'h0, aop}, 32'h4);
    chk("and.wbd", {24'h0, wbd}, 32'h0A);
    flags("and", 1'b0, 1'b0);

    op_chk("movi80", 4'b1111, 2'd2, 2'd0, 1'b1, 8'h80, 8'h80);
    op_chk("add_rr", 4'b0010, 2'd2, 2'd2, 1'b0, 8'h00, 8'h00);
    flags("add_rr", 1'b1, 1'b1);

    exec(4'b0000, 2'd2, 2'd2, 1'b1, 8'h33, 1'b1, wbn, wbat, rdyat, wbd, wbr, aop, b1);
    chk("nop.wbn", wbn, 0);
    chk("nop.rdy", rdyat, 2);
    chk("nop.busy", {31'h0, b1}, 32'd1);
    flags("nop", 1'b1, 1'b1);
    dbg("nop.r2", 2'd2, 8'h00);

    exec(4'b1111, 2'd3, 2'd0, 1'b1, 8'h55, 1'b1, wbn, wbat, rdyat, wbd, wbr, aop, b1);
    chk("hold.wbn", wbn, 1);
    chk("hold.wbd", {24'h0, wbd}, 32'h55);
    chk("hold.rdy", rdyat, 4);
    tick();
    chk("hold.idle_wbv", {31'h0, wb_valid}, 32'd0);
    dbg("hold.r3", 2'd3, 8'h55);
    dbg("hold.r0", 2'd0, 8'h0A);

    // ADD r0,r1 aborted by reset while in EXEC.
    instr_valid = 1'b1; instr_op = 4'b0010; instr_rd = 2'd0; instr_rs = 2'd1;
    instr_use_imm = 1'b0;
    tick();
    instr_valid = 1'b0;
    tick();
    chk("abort.busy", {31'h0, busy}, 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort.wbv", {31'h0, wb_valid}, 32'd0);
    chk("abort.ready", {31'h0, instr_ready}, 32'd1);
    chk("abort.alu_a", {24'h0, alu_a}, 32'h0);
    flags("abort", 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) dbg("abort.rf", i[1:0], 8'h00);
    tick();
    chk("abort.wbv2", {31'h0, wb_valid}, 32'd0);
    chk("abort.ready2", {31'h0, instr_ready}, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_exec_ctrl.md
Name: alu_exec_ctrl

Overview:
- Multi-cycle execute sequencer that sits directly upstream of the combinational 8-bit ALU.
- Accepts one instruction at a time over a valid/ready handshake and reads operands from an internal 4x8-bit register file.
- Drives the ALU's a/b/cin/operation inputs from registers, captures the ALU sum, and writes the result back with Z/C flags.
- Gives the processor core a single execute stage with registered ALU inputs.

Parameters:
- NREGS, 4, number of 8-bit general registers (power of two; address width = log2(NREGS)).
- RST_VAL, 8'h00, reset value of every register-file entry.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- instr_valid  input  1  instruction present.
- instr_ready  output  1  block can accept; high only in IDLE.
- instr_op  input  4  0000 NOP, 0001 SUB, 0010 ADD, 0101 XOR, 1111 MOVI; all other codes AND.
- instr_rd  input  2  destination register and first operand.
- instr_rs  input  2  second-operand register.
- instr_use_imm  input  1  second operand = instr_imm instead of reg[rs].
- instr_imm  input  8  immediate operand.
- alu_a  output  8  registered ALU operand a.
- alu_b  output  8  registered ALU operand b.
- alu_cin  output  1  registered carry-in, always 0.
- alu_op  output  4  registered ALU operation code.
- alu_sum  input  8  ALU result, combinational from alu_a/alu_b/alu_op.
- alu_cout  input  1  ALU carry-out.
- wb_valid  output  1  one-cycle pulse on register write-back.
- wb_rd  output  2  register written.
- wb_data  output  8  value written.
- flag_z  output  1  zero flag, sticky until the next write-back.
- flag_c  output  1  carry/borrow flag, sticky until the next write-back.
- busy  output  1  high in every state except IDLE.
- dbg_addr  input  2  debug read address.
- dbg_data  output  8  reg[dbg_addr], combinational read.

Behaviour:
- Reset values:
  - FSM goes to IDLE; instr_ready=1, busy=0.
  - alu_a, alu_b, alu_op, alu_cin, wb_rd and wb_data are 0; wb_valid=0; flag_z=0, flag_c=0.
  - All register-file entries take RST_VAL.
- FSM states: IDLE, OPER, EXEC, WB.
  - IDLE: on instr_valid & instr_ready, latch op, rd, rs, use_imm and imm, then go to OPER. Otherwise stay in IDLE.
  - OPER: load alu_a=reg[rd] and alu_b=(use_imm ? imm : reg[rs]).
    - For ADD, SUB and XOR, alu_op is loaded with that same opcode.
    - For every AND code, alu_op=0100.
    - For NOP, go straight to IDLE: no write-back, flags unchanged.
    - Otherwise go to EXEC.
  - EXEC: ALU inputs held stable; capture result=(op==MOVI ? alu_b : alu_sum) and the carry; go to WB.
  - WB: write reg[rd]=result and pulse wb_valid for one cycle with wb_rd/wb_data; update flag_z and flag_c; go to IDLE.
- Latency: handshake at cycle N; wb_valid at cycle N+3; instr_ready high again at N+4. NOP returns to IDLE at N+2.
- Back-to-back: an instruction accepted in the IDLE cycle right after WB sees the new register value. There are no hazards.
- Arithmetic: 8-bit, wrapping modulo 256.
- Flags:
  - flag_z = (result==8'h00).
  - ADD: flag_c = carry out.
  - SUB: flag_c = borrow (a<b unsigned).
  - XOR, AND and MOVI: flag_c = 0.
- rd==rs is legal; both operands read the same value.
- instr_valid while busy: ignored, since instr_ready=0. Upstream must hold valid until ready.
- Reset asserted mid-operation: the next edge forces IDLE and reset values. No write-back or flag update occurs for the aborted instruction.
- dbg_data reflects a write one cycle after the WB edge.

Optional Feature:
- Macro: ALU_CARRY_INT_EN.
- Defined: flag_c comes from an internal 9-bit add/subtract of alu_a and alu_b. alu_cout is ignored and may be left unconnected.
- Undefined: flag_c = alu_cout captured in EXEC for ADD/SUB, and 0 for the other ops.
- All other behaviour is identical in both builds.

Test Plan:
- Reset, then MOVI r0,#8'hF0 then MOVI r1,#8'h20 -> two wb_valid pulses; dbg r0=F0, r1=20; flag_z=0, flag_c=0.
- ADD r0,r1 (r0=F0, r1=20) -> wb_data=8'h10, flag_c=1, flag_z=0, wb_valid exactly 3 cycles after handshake.
- SUB r1,#8'h20 (imm) -> wb_data=00, flag_z=1, flag_c=0; then SUB r1,#8'h01 -> wb_data=FF, flag_c=1.
- XOR r0,r0 -> wb_data=00, flag_z=1; then op=4'b1010 (AND) with r0=AA and r1=0F -> alu_op=0100, wb_data=0A.
- NOP -> no wb_valid, flags unchanged, instr_ready high 2 cycles after handshake; instr_valid held during busy -> no second accept.
- ADD in flight, rst asserted in EXEC -> no wb_valid, all registers 00, instr_ready=1 the cycle after reset.
